// File: rtl/pixel_frame_sequencer.sv
// Frame capture controller: global erase, programmable exposure, then a raster
// readout with a per-pixel read/convert handshake to the column ADC and a valid/ready result stream.
module pixel_frame_sequencer #(
  parameter int NUM_PIXELS   = 64,
  parameter int ERASE_CYCLES = 5,
  parameter int EXP_W        = 16,
  parameter int ADC_W        = 8,
  parameter int ADC_TIMEOUT  = 32,
  localparam int AW          = $clog2(NUM_PIXELS) / 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_continuous,
  input  logic [EXP_W-1:0]  i_exp_time,
  output logic              o_erase,
  output logic              o_expose,
  output logic              o_read,
  output logic              o_convert,
  output logic [AW-1:0]     o_row_addr,
  output logic [AW-1:0]     o_col_addr,
  output logic              o_adc_start,
  input  logic              i_adc_done,
  input  logic [ADC_W-1:0]  i_adc_data,
  output logic              o_pix_valid,
  input  logic              i_pix_ready,
  output logic [ADC_W-1:0]  o_pix_data,
  output logic [2*AW-1:0]   o_pix_addr,
  output logic              o_frame_done,
  output logic              o_busy,
  output logic              o_adc_err
);

  localparam int ERASE_W = $clog2(ERASE_CYCLES + 1);
  localparam int TO_W    = $clog2(ADC_TIMEOUT + 1);
  localparam int CNT_A   = (EXP_W > ERASE_W) ? EXP_W : ERASE_W;
  localparam int CNT_W   = (CNT_A > TO_W) ? CNT_A : TO_W;

  typedef enum logic [2:0] {
    S_IDLE, S_ERASE, S_EXPOSE, S_READ, S_CONVERT, S_OUTPUT, S_DONE
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [EXP_W-1:0]  r_exp;
  logic [AW-1:0]     r_row;
  logic [AW-1:0]     r_col;
  logic              r_erase, r_expose, r_read, r_convert, r_adc_start;
  logic              r_pix_valid, r_frame_done, r_busy, r_adc_err;
  logic [ADC_W-1:0]  r_pix_data;
  logic [2*AW-1:0]   r_pix_addr;

  logic [EXP_W-1:0]  w_exp_lat;
  logic [2*AW-1:0]   w_addr_next;
  logic              w_last;

  // A zero exposure request still exposes for one clock.
  assign w_exp_lat   = (i_exp_time == '0) ? EXP_W'(1) : i_exp_time;
  assign w_addr_next = {r_row, r_col} + (2*AW)'(1);
  assign w_last      = &{r_row, r_col};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_exp        <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_erase      <= 1'b0;
      r_expose     <= 1'b0;
      r_read       <= 1'b0;
      r_convert    <= 1'b0;
      r_adc_start  <= 1'b0;
      r_pix_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
      r_adc_err    <= 1'b0;
      r_pix_data   <= '0;
      r_pix_addr   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state   <= S_ERASE;
            r_erase   <= 1'b1;
            r_busy    <= 1'b1;
            r_cnt     <= CNT_W'(1);
            r_exp     <= w_exp_lat;
            r_adc_err <= 1'b0;
          end
        end
        S_ERASE: begin
          if (r_cnt == CNT_W'(ERASE_CYCLES)) begin
            r_state  <= S_EXPOSE;
            r_erase  <= 1'b0;
            r_expose <= 1'b1;
            r_cnt    <= CNT_W'(1);
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_EXPOSE: begin
          if (r_cnt == CNT_W'(r_exp)) begin
            r_state  <= S_READ;
            r_expose <= 1'b0;
            r_read   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_READ: begin
          r_state     <= S_CONVERT;
          r_convert   <= 1'b1;
          r_adc_start <= 1'b1;
          r_cnt       <= CNT_W'(1);
        end
        S_CONVERT: begin
          r_adc_start <= 1'b0;
          // A real result wins over a timeout landing in the same cycle.
          if (i_adc_done || (r_cnt == CNT_W'(ADC_TIMEOUT))) begin
            r_state     <= S_OUTPUT;
            r_read      <= 1'b0;
            r_convert   <= 1'b0;
            r_pix_valid <= 1'b1;
            r_pix_addr  <= {r_row, r_col};
            r_pix_data  <= i_adc_done ? i_adc_data : '1;
            if (!i_adc_done) r_adc_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_OUTPUT: begin
          if (i_pix_ready) begin
            r_pix_valid <= 1'b0;
            if (w_last) begin
              r_state      <= S_DONE;
              r_frame_done <= 1'b1;
              r_row        <= '0;
              r_col        <= '0;
              r_pix_addr   <= '0;
              r_pix_data   <= '0;
            end else begin
              r_state        <= S_READ;
              r_read         <= 1'b1;
              {r_row, r_col} <= w_addr_next;
            end
          end
        end
        S_DONE: begin
          r_frame_done <= 1'b0;
          // Back-to-back frames keep adc_err so a fault in any frame stays visible.
          if (i_continuous) begin
            r_state <= S_ERASE;
            r_erase <= 1'b1;
            r_cnt   <= CNT_W'(1);
            r_exp   <= w_exp_lat;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_erase      = r_erase;
  assign o_expose     = r_expose;
  assign o_read       = r_read;
  assign o_convert    = r_convert;
  assign o_row_addr   = r_row;
  assign o_col_addr   = r_col;
  assign o_adc_start  = r_adc_start;
  assign o_pix_valid  = r_pix_valid;
  assign o_pix_data   = r_pix_data;
  assign o_pix_addr   = r_pix_addr;
  assign o_frame_done = r_frame_done;
  assign o_busy       = r_busy;
  assign o_adc_err    = r_adc_err;

endmodule

// File: tb/tb_pixel_frame_sequencer.sv
// Directed bench for pixel_frame_sequencer: frame timing, readout order, backpressure,
// ADC timeout, exposure boundaries, continuous mode and mid-frame reset.
module tb_pixel_frame_sequencer;

  logic        i_clk = 1'b0;
  logic        i_reset, i_start, i_continuous;
  logic [15:0] i_exp_time;
  logic        o_erase, o_expose, o_read, o_convert;
  logic [2:0]  o_row_addr, o_col_addr;
  logic        o_adc_start;
  logic        i_adc_done;
  logic [7:0]  i_adc_data;
  logic        o_pix_valid;
  logic        i_pix_ready;
  logic [7:0]  o_pix_data;
  logic [5:0]  o_pix_addr;
  logic        o_frame_done, o_busy, o_adc_err;

  pixel_frame_sequencer dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_continuous(i_continuous),
    .i_exp_time(i_exp_time), .o_erase(o_erase), .o_expose(o_expose), .o_read(o_read),
    .o_convert(o_convert), .o_row_addr(o_row_addr), .o_col_addr(o_col_addr),
    .o_adc_start(o_adc_start), .i_adc_done(i_adc_done), .i_adc_data(i_adc_data),
    .o_pix_valid(o_pix_valid), .i_pix_ready(i_pix_ready), .o_pix_data(o_pix_data),
    .o_pix_addr(o_pix_addr), .o_frame_done(o_frame_done), .o_busy(o_busy),
    .o_adc_err(o_adc_err)
  );

  always #5 i_clk = ~i_clk;

  int n_total = 0;
  int n_bad   = 0;

  // Per-frame observations gathered by run_frame.
  int   cyc, done_cyc, first_erase, n_erase, n_expose, n_beats, n_adcs, excl_bad, stall_bad;
  int   stall_at = -1, stall_len = 0, to_pix = -1;
  int   mid_start_cyc = -1, exp_chg_cyc = -1, cont_off_cyc = -1;
  logic [15:0] exp_chg_val = '0;
  logic err_first, err_at_done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({o_erase, o_expose, o_read, o_convert, o_row_addr, o_col_addr, o_adc_start,
                o_pix_valid, o_pix_data, o_pix_addr, o_frame_done, o_busy, o_adc_err});
  endfunction

  // Runs one frame from the negedge of the start cycle until frame_done is seen,
  // acting as the ADC (done one cycle after adc_start) and the downstream sink.
  task automatic run_frame();
    int   stall_left;
    bit   prev_start;
    logic [7:0] want_d;
    cyc = 0; done_cyc = -1; first_erase = -1;
    n_erase = 0; n_expose = 0; n_beats = 0; n_adcs = 0; excl_bad = 0; stall_bad = 0;
    stall_left = stall_len; prev_start = 1'b0;
    while (done_cyc < 0 && cyc < 3000) begin
      @(negedge i_clk);
      cyc++;
      i_start = (cyc == mid_start_cyc);
      if (cyc == exp_chg_cyc) i_exp_time = exp_chg_val;
      if (cyc == cont_off_cyc) i_continuous = 1'b0;
      if (cyc == 1) err_first = o_adc_err;
      if (o_erase && first_erase < 0) first_erase = cyc;
      n_erase  += int'(o_erase);
      n_expose += int'(o_expose);
      n_adcs   += int'(o_adc_start);
      if ((int'(o_erase) + int'(o_expose) + int'(o_read) + int'(o_frame_done) > 1) ||
          (o_convert && !o_read))
        excl_bad++;
      i_adc_done = prev_start && (n_beats != to_pix);
      i_adc_data = 8'(n_beats) ^ 8'h5A;
      prev_start = o_adc_start;
      want_d = (n_beats == to_pix) ? 8'hFF : (8'(n_beats) ^ 8'h5A);
      i_pix_ready = 1'b1;
      if (o_pix_valid && n_beats == stall_at && stall_left > 0) begin
        i_pix_ready = 1'b0;
        stall_left--;
        if (o_pix_addr !== 6'(stall_at) || o_pix_data !== want_d || o_adc_start) stall_bad++;
      end
      if (o_pix_valid && i_pix_ready) begin
        chk("pix_addr", 32'(o_pix_addr), 32'(n_beats));
        chk("pix_data", 32'(o_pix_data), 32'(want_d));
        if (n_beats == 8) begin
          chk("wrap_row", 32'(o_row_addr), 32'd1);
          chk("wrap_col", 32'(o_col_addr), 32'd0);
        end
        n_beats++;
      end
      if (o_frame_done) begin
        done_cyc    = cyc;
        err_at_done = o_adc_err;
      end
    end
    if (done_cyc < 0) chk("frame_done_timeout", 32'd0, 32'd1);
    i_adc_done = 1'b0;
  endtask

  initial begin
    int seen_valid;
    i_reset = 1'b1; i_start = 1'b0; i_continuous = 1'b0; i_exp_time = 16'd10;
    i_adc_done = 1'b0; i_adc_data = '0; i_pix_ready = 1'b1;
    repeat (2) @(negedge i_clk);
    chk("reset_outs", outs(), 32'd0);
    i_reset = 1'b0;
    @(negedge i_clk);
    chk("idle_outs", outs(), 32'd0);

    // Nominal frame with a stray start during readout.
    i_exp_time = 16'd10; i_start = 1'b1; mid_start_cyc = 100;
    run_frame();
    mid_start_cyc = -1;
    chk("nom_first_erase", 32'(first_erase), 32'd1);
    chk("nom_erase_len", 32'(n_erase), 32'd5);
    chk("nom_expose_len", 32'(n_expose), 32'd10);
    chk("nom_beats", 32'(n_beats), 32'd64);
    chk("nom_adc_starts", 32'(n_adcs), 32'd64);
    chk("nom_exclusive", 32'(excl_bad), 32'd0);
    chk("nom_done_time", 32'(done_cyc - first_erase), 32'd271);
    @(negedge i_clk);
    chk("nom_back_idle", outs(), 32'd0);

    // Backpressure: sink stalls 7 cycles on pixel 9.
    stall_at = 9; stall_len = 7; i_start = 1'b1;
    run_frame();
    stall_at = -1; stall_len = 0;
    chk("bp_stall_stable", 32'(stall_bad), 32'd0);
    chk("bp_beats", 32'(n_beats), 32'd64);
    chk("bp_done_time", 32'(done_cyc - first_erase), 32'd278);
    @(negedge i_clk);

    // ADC never answers pixel 0.
    to_pix = 0; i_start = 1'b1;
    run_frame();
    to_pix = -1;
    chk("to_err_at_done", 32'(err_at_done), 32'd1);
    chk("to_done_time", 32'(done_cyc - first_erase), 32'd301);
    @(negedge i_clk);
    chk("to_err_sticky_idle", 32'(o_adc_err), 32'd1);
    chk("to_busy_idle", 32'(o_busy), 32'd0);

    // Zero exposure; the accepted start also clears adc_err.
    i_exp_time = 16'd0; i_start = 1'b1;
    run_frame();
    chk("exp0_err_cleared", 32'(err_first), 32'd0);
    chk("exp0_expose_len", 32'(n_expose), 32'd1);
    chk("exp0_done_time", 32'(done_cyc - first_erase), 32'd262);
    @(negedge i_clk);

    // Continuous mode: exposure changed mid-frame takes effect on the next frame.
    i_continuous = 1'b1; i_exp_time = 16'd10; i_start = 1'b1;
    exp_chg_cyc = 50; exp_chg_val = 16'd3;
    run_frame();
    exp_chg_cyc = -1;
    chk("cont1_expose_len", 32'(n_expose), 32'd10);
    chk("cont1_done_time", 32'(done_cyc - first_erase), 32'd271);
    cont_off_cyc = 20;
    run_frame();
    cont_off_cyc = -1;
    chk("cont2_first_erase", 32'(first_erase), 32'd1);
    chk("cont2_expose_len", 32'(n_expose), 32'd3);
    chk("cont2_done_time", 32'(done_cyc - first_erase), 32'd264);
    @(negedge i_clk);
    chk("cont_stop_idle", outs(), 32'd0);

    // Reset during EXPOSE, then a late adc_done.
    i_exp_time = 16'd10; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (7) @(negedge i_clk);
    chk("rx_in_expose", 32'(o_expose), 32'd1);
    i_reset = 1'b1;
    @(negedge i_clk);
    i_reset = 1'b0;
    chk("rx_outs_zero", outs(), 32'd0);
    i_adc_done = 1'b1; i_adc_data = 8'h33;
    @(negedge i_clk);
    i_adc_done = 1'b0;
    seen_valid = 0;
    repeat (3) begin
      @(negedge i_clk);
      seen_valid += int'(o_pix_valid) + int'(o_busy);
    end
    chk("rx_late_done_ignored", 32'(seen_valid), 32'd0);

    // Reset during CONVERT, then a late adc_done.
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    for (int i = 0; i < 50 && !o_convert; i++) @(negedge i_clk);
    chk("rc_in_convert", 32'(o_convert), 32'd1);
    i_reset = 1'b1;
    @(negedge i_clk);
    i_reset = 1'b0;
    chk("rc_outs_zero", outs(), 32'd0);
    i_adc_done = 1'b1; i_adc_data = 8'h77;
    @(negedge i_clk);
    i_adc_done = 1'b0;
    seen_valid = 0;
    repeat (3) begin
      @(negedge i_clk);
      seen_valid += int'(o_pix_valid) + int'(o_busy);
    end
    chk("rc_late_done_ignored", 32'(seen_valid), 32'd0);

    // Start and reset together: reset wins.
    i_start = 1'b1; i_reset = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0; i_reset = 1'b0;
    chk("start_vs_reset", outs(), 32'd0);
    @(negedge i_clk);
    chk("start_vs_reset_idle", 32'(o_busy), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/pixel_frame_sequencer.md
# pixel_frame_sequencer

Frame-level controller for the pixel array. It accepts a start request and runs one complete capture: global erase, programmable exposure, then a raster readout. Each pixel goes through a read/convert handshake with the column ADC, and each result is handed downstream through a valid/ready port. It sits between the system control logic and the pixel array/ADC, and drives the array's erase, expose, read, convert and row/column address lines.

## Interface
- `NUM_PIXELS`, 64, total pixels; must be a perfect square with a power-of-two side (side = sqrt(NUM_PIXELS), AW = clog2(side)).
- `ERASE_CYCLES`, 5, erase phase length in clocks (≥1).
- `EXP_W`, 16, exposure-time register width.
- `ADC_W`, 8, ADC result width.
- `ADC_TIMEOUT`, 32, max CONVERT cycles waiting for adc_done (≥2).

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: frame request; sampled only in IDLE.
- `continuous` in 1: sampled at frame end; 1 = start next frame immediately.
- `exp_time` in EXP_W: exposure length in clocks; latched on accepted start and at continuous restart.
- `erase`, `expose`, `read`, `convert` out 1: pixel array phase controls.
- `row_addr`, `col_addr` out AW: current pixel address.
- `adc_start` out 1: one-cycle conversion request.
- `adc_done` in 1: conversion complete; `adc_data` in ADC_W is valid in the same cycle.
- `pix_valid` out 1, `pix_ready` in 1, `pix_data` out ADC_W, `pix_addr` out 2·AW ({row,col}): output stream.
- `frame_done` out 1: one-cycle pulse after the last pixel is accepted.
- `busy` out 1: high in every state except IDLE.
- `adc_err` out 1: sticky timeout flag; cleared only by reset or by an accepted `start`.

## Operation
- States: IDLE, ERASE, EXPOSE, READ, CONVERT, OUTPUT, DONE.
- IDLE: all outputs 0, addresses 0. `start`=1 → ERASE; latch exp_time (0 is treated as 1); clear adc_err.
- ERASE: `erase`=1 for exactly ERASE_CYCLES cycles → EXPOSE.
- EXPOSE: `expose`=1 for exactly the latched exp_time cycles → READ with row=col=0.
- READ: `read`=1 for 1 cycle (settle) → CONVERT.
- CONVERT:
  - `read`=1 and `convert`=1 throughout.
  - `adc_start`=1 only in the first CONVERT cycle.
  - `adc_done` is honoured in any CONVERT cycle, including the first. On adc_done, capture adc_data into pix_data and go to OUTPUT.
  - If adc_done is absent for ADC_TIMEOUT cycles: pix_data = all ones, set adc_err, go to OUTPUT.
- OUTPUT:
  - `pix_valid`=1; pix_data and pix_addr are held stable until `pix_valid`&&`pix_ready`.
  - On acceptance: if not the last pixel, increment the address and go to READ. If it is the last pixel, go to DONE.
  - Address order: col increments first; when col wraps side-1→0, row increments. The last pixel is row=col=side-1.
- DONE: `frame_done`=1 for 1 cycle; addresses return to 0.
  - If `continuous`=1 → ERASE with a fresh exp_time latch (adc_err is not cleared).
  - Otherwise → IDLE.
- `start` outside IDLE is ignored. A `start` and `reset` in the same cycle: reset wins.
- Reset mid-frame: the next cycle is IDLE, all outputs 0, and any in-flight conversion result is discarded. A late adc_done arriving in IDLE is ignored.

## Timing
- Reset value of every output: 0 (this includes pix_data, pix_addr, row_addr, col_addr and adc_err).
- Start sampled in cycle 0 → erase high in cycles 1..E (E = ERASE_CYCLES).
- Exposure: expose high in cycles E+1..E+T (T = latched exp_time).
- Per pixel: READ 1 cycle + CONVERT (1..ADC_TIMEOUT) + OUTPUT (≥1). Minimum 3 cycles per pixel.
- row_addr and col_addr change only on an OUTPUT acceptance edge or on entry to DONE/IDLE. They are stable for the whole read/convert window of a pixel.
- pix_addr equals {row_addr, col_addr} while pix_valid is high.
- Phase outputs are mutually exclusive, except that read and convert are both high in CONVERT.

## Test plan
- Reset: assert reset during EXPOSE and during CONVERT → next cycle all outputs 0 and state is IDLE. adc_done then pulsed → no pix_valid.
- Nominal frame with NUM_PIXELS=64, E=5, exp_time=10, adc_done one cycle after adc_start, pix_ready=1:
  - 64 pix_valid beats with pix_addr 0..63 in order.
  - frame_done exactly 5+10+64·4 = 271 cycles after the first erase cycle.
- Backpressure: pix_ready low for 7 cycles at pixel 9 → pix_valid, pix_data and pix_addr=9 held stable; no adc_start issued until acceptance.
- ADC timeout: adc_done never asserted for pixel 0 with ADC_TIMEOUT=32 → OUTPUT after 32 CONVERT cycles, pix_data=0xFF, adc_err=1 (sticky through the frame). The next accepted start clears adc_err.
- Boundaries:
  - exp_time=0 → expose high for exactly 1 cycle.
  - start pulsed mid-frame → ignored.
  - Column wrap 7→0 increments row.
- Continuous mode: continuous=1 with exp_time changed mid-frame → erase begins the cycle after frame_done, and the new exp_time is used for the second frame.
